// File: rtl/sig_tx_pkg.sv
// Shared types and helpers for the signature/halt UART streamer.
// SIGTX_CRLF_EN selects a CR+LF line ending instead of LF only.
package sig_tx_pkg;

  localparam logic [1:0] WR_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HEX  = 3'd2,
    ST_CR   = 3'd3,
    ST_NL   = 3'd4
  } fmt_state_e;

`ifdef SIGTX_CRLF_EN
  localparam int unsigned CHARS_PER_WORD = 32'd10;
`else
  localparam int unsigned CHARS_PER_WORD = 32'd9;
`endif

  // 0x57 is 'a' minus ten, so nibbles 10..15 land on 'a'..'f'
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib < 4'd10) begin
      chr = 8'h30 + {4'h0, nib};
    end else begin
      chr = 8'h57 + {4'h0, nib};
    end
    return chr;
  endfunction

endpackage

// File: rtl/sig_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready input handshake.
// Ready is raised on the final cycle of the stop bit, so characters can run back-to-back with no idle time.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 32'd868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned BW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 32'd1);

  logic [BW-1:0] baud_r;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    data_r;
  logic          busy_r;
  logic          tx_r;
  logic          last_s;
  logic          accept_s;

  assign last_s   = busy_r & (bit_cnt_r == 4'd9) & (baud_r == BAUD_LAST);
  assign o_ready  = ~busy_r | last_s;
  assign accept_s = i_valid & o_ready;
  assign o_tx     = tx_r;
  assign o_busy   = busy_r;

  // Bit timing: start, eight data bits shifted out LSB first, stop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      baud_r    <= '0;
      bit_cnt_r <= 4'd0;
      data_r    <= 8'h00;
      busy_r    <= 1'b0;
      tx_r      <= 1'b1;
    end else if (accept_s) begin
      baud_r    <= '0;
      bit_cnt_r <= 4'd0;
      data_r    <= i_data;
      busy_r    <= 1'b1;
      tx_r      <= 1'b0;
    end else if (busy_r) begin
      if (baud_r == BAUD_LAST) begin
        baud_r <= '0;
        if (bit_cnt_r == 4'd9) begin
          busy_r <= 1'b0;
          tx_r   <= 1'b1;
        end else begin
          // ones shift in behind the data so the ninth bit emitted is the stop bit
          bit_cnt_r <= bit_cnt_r + 4'd1;
          tx_r      <= data_r[0];
          data_r    <= {1'b1, data_r[7:1]};
        end
      end else begin
        baud_r <= baud_r + BW'(1);
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

endmodule

// File: rtl/sig_uart_tx.sv
// Signature/halt MMIO responder: buffers word stores and streams them as hex text lines on a UART pin.
// Define SIGTX_CRLF_EN to end each line with CR+LF instead of LF.
module sig_uart_tx
  import sig_tx_pkg::*;
#(
  parameter logic [31:0] SIG_ADDR     = 32'h8E000000,
  parameter logic [31:0] HALT_ADDR    = 32'h8F000000,
  parameter int unsigned FIFO_DEPTH   = 32'd16,
  parameter int unsigned CLKS_PER_BIT = 32'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [1:0]  i_dmem_wr_type,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_halt_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [31:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  fmt_state_e    state_r;
  fmt_state_e    state_nxt_s;
  logic [31:0]   word_r;
  logic [2:0]    idx_r;
  logic          halt_pending_r;
  logic          overflow_r;
  logic          halt_done_r;
  logic          sig_hit_s;
  logic          halt_hit_s;
  logic          push_s;
  logic          pop_s;
  logic          byte_valid_s;
  logic [7:0]    byte_data_s;
  logic          ser_ready_s;
  logic          ser_busy_s;
  logic          accept_s;

  assign sig_hit_s  = (i_dmem_wr_type == WR_WORD) & (i_dmem_addr == SIG_ADDR) & ~halt_pending_r;
  assign halt_hit_s = (i_dmem_wr_type == WR_WORD) & (i_dmem_addr == HALT_ADDR);
  assign push_s     = sig_hit_s & (count_r != FULL_CNT);
  assign pop_s      = (state_r == ST_LOAD);
  assign accept_s   = byte_valid_s & ser_ready_s;

  assign o_busy      = (count_r != '0) | (state_r != ST_IDLE) | ser_busy_s;
  assign o_overflow  = overflow_r;
  assign o_halt_done = halt_done_r;

  // FIFO storage; contents need no reset because count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_dmem_wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + (AW + 1)'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - (AW + 1)'(1);
      end
    end
  end

  // Formatter state register and the word being printed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      word_r  <= 32'h0;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        word_r <= mem_r[rd_ptr_r];
        idx_r  <= 3'd7;
      end else if ((state_r == ST_HEX) && accept_s) begin
        word_r <= {word_r[27:0], 4'h0};
        idx_r  <= idx_r - 3'd1;
      end
    end
  end

  // Formatter next state and byte offered to the serializer.
  always_comb begin
    state_nxt_s  = state_r;
    byte_valid_s = 1'b0;
    byte_data_s  = 8'h0A;
    case (state_r)
      ST_IDLE: begin
        if (count_r != '0) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_HEX;
      end
      ST_HEX: begin
        byte_valid_s = 1'b1;
        byte_data_s  = hex2ascii(word_r[31:28]);
        if (accept_s && (idx_r == 3'd0)) begin
`ifdef SIGTX_CRLF_EN
          state_nxt_s = ST_CR;
`else
          state_nxt_s = ST_NL;
`endif
        end else begin
          state_nxt_s = ST_HEX;
        end
      end
      ST_CR: begin
        byte_valid_s = 1'b1;
        byte_data_s  = 8'h0D;
        if (accept_s) begin
          state_nxt_s = ST_NL;
        end else begin
          state_nxt_s = ST_CR;
        end
      end
      ST_NL: begin
        byte_valid_s = 1'b1;
        byte_data_s  = 8'h0A;
        if (accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_NL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sticky flags; stores that arrive after a halt request are ignored and never count as overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_pending_r <= 1'b0;
      overflow_r     <= 1'b0;
      halt_done_r    <= 1'b0;
    end else begin
      if (halt_hit_s) begin
        halt_pending_r <= 1'b1;
      end
      if (sig_hit_s && (count_r == FULL_CNT)) begin
        overflow_r <= 1'b1;
      end
      if (halt_pending_r && (count_r == '0) && (state_r == ST_IDLE) && !ser_busy_s) begin
        halt_done_r <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .i_valid(byte_valid_s),
    .o_ready(ser_ready_s),
    .i_data (byte_data_s),
    .o_tx   (o_uart_tx),
    .o_busy (ser_busy_s)
  );

endmodule

// File: tb/tb_sig_uart_tx.sv
// Scoreboard bench for sig_uart_tx: stimulus queues expected characters, a UART receiver pops and compares.
module tb_sig_uart_tx;

  localparam int CLKS = 8;
  localparam int DEPTH = 16;
  localparam logic [31:0] SIG = 32'h8E000000;
  localparam logic [31:0] HALT = 32'h8F000000;
`ifdef SIGTX_CRLF_EN
  localparam int CPW = 10;
`else
  localparam int CPW = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  wr_type = 2'b00;
  logic        tx, busy, ovf, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  string hexs = "0123456789abcdef";

  sig_uart_tx #(
    .SIG_ADDR(SIG), .HALT_ADDR(HALT), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk(clk), .rst(rst), .i_dmem_addr(addr), .i_dmem_wdata(wdata),
    .i_dmem_wr_type(wr_type), .o_uart_tx(tx), .o_busy(busy),
    .o_overflow(ovf), .o_halt_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_chars(input string s);
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
  endtask

  task automatic expect_word(input string s);
    expect_chars(s);
`ifdef SIGTX_CRLF_EN
    sb.push_back(8'h0D);
`endif
    sb.push_back(8'h0A);
  endtask

  // drive a store; it is captured at the following rising edge
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    @(posedge clk); #1;
    addr = a; wdata = d; wr_type = t;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    wr_type = 2'b00; addr = 32'h0;
  endtask

  task automatic wait_idle(input int limit, input string name, output int n);
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // UART receiver: samples mid-bit on falling clock edges, compares each frame with the queue head
  initial begin
    int cnt;
    int k;
    logic act;
    logic [9:0] bits;
    logic [7:0] exp;
    act = 1'b0; cnt = 0; bits = 10'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt >= CLKS / 2 && ((cnt - CLKS / 2) % CLKS) == 0) begin
          k = (cnt - CLKS / 2) / CLKS;
          bits[k] = tx;
          if (k == 9) begin
            act = 1'b0;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL uart_unexpected: got frame %0h expected no character", bits);
            end else begin
              exp = sb.pop_front();
              chk("uart_char", {22'd0, bits}, {22'd0, 1'b1, exp, 1'b0});
            end
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic early;
    string s;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    // 1: single word, start-bit latency and total duration
    expect_word("deadbeef");
    drive(SIG, 32'hDEADBEEF, 2'b11);
    idle();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1; chk("t1_tx_e1", {31'd0, tx}, 32'd1);
    @(posedge clk); #1; chk("t1_tx_e2", {31'd0, tx}, 32'd1);
    @(posedge clk); #1; chk("t1_tx_e3", {31'd0, tx}, 32'd0);
    wait_idle(2000, "t1_idle", n);
    chk("t1_cycles", n, CPW * 10 * CLKS);
    chk("t1_sb_empty", sb.size(), 32'd0);

    // 2: wrong store type and aliasing address are ignored
    drive(SIG, 32'h12345678, 2'b10);
    drive(32'h8E000004, 32'h12345678, 2'b11);
    idle();
    repeat (4) begin
      @(posedge clk); #1;
      chk("t2_tx", {31'd0, tx}, 32'd1);
      chk("t2_busy", {31'd0, busy}, 32'd0);
    end

    // 3: one word in flight, then 17 back-to-back pushes; the 17th hits a full FIFO
    expect_word("89abcdef");
    drive(SIG, 32'h89ABCDEF, 2'b11);
    idle();
    repeat (5) @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      drive(SIG, 32'h11111111 * i, 2'b11);
      if (i < 16) begin
        s = "";
        for (int j = 0; j < 8; j++) s = {s, hexs.substr(i, i)};
        expect_word(s);
      end
      if (i == 16) chk("t3_ovf_before", {31'd0, ovf}, 32'd0);
    end
    idle();
    chk("t3_ovf_after", {31'd0, ovf}, 32'd1);
    wait_idle(20000, "t3_idle", n);
    chk("t3_sb_empty", sb.size(), 32'd0);
    chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);

    // 5: reset in a data bit of the third character
    expect_chars("12");
    drive(SIG, 32'h12345678, 2'b11);
    idle();
    repeat (190) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t5_tx", {31'd0, tx}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ovf", {31'd0, ovf}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_sb_empty", sb.size(), 32'd0);
    expect_word("cafef00d");
    drive(SIG, 32'hCAFEF00D, 2'b11);
    idle();
    wait_idle(2000, "t5_idle", n);
    chk("t5_cycles", n, CPW * 10 * CLKS + 3);
    chk("t5_sb_after", sb.size(), 32'd0);

    // 4: halt after a word; done only once the line has drained, later stores ignored
    expect_word("00000001");
    drive(SIG, 32'h00000001, 2'b11);
    drive(HALT, 32'h0, 2'b11);
    idle();
    early = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      if (done) early = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("t4_busy_fall", {31'd0, busy}, 32'd0);
    chk("t4_no_early_done", {31'd0, early | done}, 32'd0);
    @(posedge clk); #1;
    chk("t4_done", {31'd0, done}, 32'd1);
    drive(SIG, 32'hFFFFFFFF, 2'b11);
    idle();
    repeat (20) @(posedge clk);
    #1;
    chk("t4_post_busy", {31'd0, busy}, 32'd0);
    chk("t4_post_tx", {31'd0, tx}, 32'd1);
    chk("t4_done_stays", {31'd0, done}, 32'd1);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);

    repeat (2 * 10 * CLKS) @(posedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
